// File: rtl/credit_rx_buffer_if.sv
// ---------------------------------------------------------------------------
// credit_rx_buffer_if
//
// Bundles the inbound credit-flow stream, the outbound valid/ready stream
// and the status outputs of credit_rx_buffer.
//
// Parameters
//   DATA_WIDTH  payload width in bits
//   DEPTH       FIFO depth; sets the width of o_count
//
// Signals
//   i_data, i_valid     inbound beat (no backpressure)
//   o_credit            one-cycle credit return pulse
//   o_data, o_valid     outbound beat
//   o_ready             downstream accept
//   o_count             FIFO occupancy
//   o_overflow          sticky overrun flag
//
// Modports
//   slave   the buffer itself (consumes inbound, produces outbound)
//   master  the environment around it (transmitter + downstream sink)
// ---------------------------------------------------------------------------
interface credit_rx_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_valid;
    logic                  o_credit;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;
    logic                  o_ready;
    logic [CW-1:0]         o_count;
    logic                  o_overflow;

    modport slave (
        input  i_data,
        input  i_valid,
        input  o_ready,
        output o_credit,
        output o_data,
        output o_valid,
        output o_count,
        output o_overflow
    );

    modport master (
        output i_data,
        output i_valid,
        output o_ready,
        input  o_credit,
        input  o_data,
        input  o_valid,
        input  o_count,
        input  o_overflow
    );
endinterface

// File: rtl/credit_rx_buffer.sv
// ---------------------------------------------------------------------------
// credit_rx_buffer
//
// Receive endpoint of the credit-flow link. Inbound beats (valid only, never
// stalled) are stored in a DEPTH-entry circular buffer and presented
// downstream as a valid/ready stream. Every beat handed downstream produces a
// registered one-cycle credit pulse back to the transmitter, whose credit
// counter starts at DEPTH, so a well-behaved transmitter cannot overrun us.
//
// Ports
//   clk    clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    credit_rx_buffer_if.slave (i_data, i_valid, o_ready in;
//          o_credit, o_data, o_valid, o_count, o_overflow out)
//
// Optional feature macro: CREDIT_RX_BYPASS_EN
//   When defined, an inbound beat arriving at an empty buffer is driven to
//   the output in the same cycle; if it is accepted right away it is never
//   written to storage. When undefined there is no input-to-output
//   combinational path and latency is always one cycle.
// ---------------------------------------------------------------------------
module credit_rx_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    credit_rx_buffer_if.slave    bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg,  count_next;
    logic          credit_reg, credit_next;
    logic          overflow_reg, overflow_next;

    logic empty;
    logic full;
    logic bypass;
    logic out_valid;
    logic pop;
    logic wr_en;
    logic rd_adv;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == FULL_COUNT);

`ifdef CREDIT_RX_BYPASS_EN
    // Empty buffer: forward the inbound beat directly. If downstream takes
    // it in the same cycle it never touches storage.
    assign bypass      = empty && bus.i_valid && bus.o_ready;
    assign out_valid   = !empty || bus.i_valid;
    assign bus.o_data  = empty ? bus.i_data : mem[rd_ptr_reg];
`else
    assign bypass      = 1'b0;
    assign out_valid   = !empty;
    assign bus.o_data  = mem[rd_ptr_reg];
`endif

    assign bus.o_valid = out_valid;

    // Any beat handed downstream (stored or bypassed) returns one credit.
    assign pop    = out_valid && bus.o_ready;
    // A pop frees the slot in the same cycle, so a full buffer with a pop
    // still accepts the inbound beat.
    assign wr_en  = bus.i_valid && (!full || pop) && !bypass;
    assign rd_adv = pop && !bypass;

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        credit_next   = pop;
        overflow_next = overflow_reg;

        if (wr_en) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (rd_adv) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        count_next = count_reg + {{(CW-1){1'b0}}, wr_en} - {{(CW-1){1'b0}}, rd_adv};

        // Dropped beat: pointers and count stay put, flag is sticky.
        if (bus.i_valid && full && !pop) begin
            overflow_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            credit_reg   <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            credit_reg   <= credit_next;
            overflow_reg <= overflow_next;
        end
    end

    // Storage carries no reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= bus.i_data;
        end
    end

    assign bus.o_credit   = credit_reg;
    assign bus.o_count    = count_reg;
    assign bus.o_overflow = overflow_reg;
endmodule

// File: tb/tb_credit_rx_buffer.sv
// ---------------------------------------------------------------------------
// tb_credit_rx_buffer
//
// Bench for credit_rx_buffer. A queue-based reference model predicts every
// output each cycle; directed scenarios plus a randomized phase drive it.
// ---------------------------------------------------------------------------
module tb_credit_rx_buffer;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;

    credit_rx_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    credit_rx_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic          exp_credit;
    logic          exp_ovf;
    int            credits_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_credit = 1'b0;
        exp_ovf    = 1'b0;
    endtask

    // One clock cycle: drive inputs, check predicted outputs, advance model.
    task automatic step(input logic iv, input logic [DW-1:0] id, input logic rdy);
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        logic          pop;
        logic          byp;
        @(negedge clk);
        bus.i_valid = iv;
        bus.i_data  = id;
        bus.o_ready = rdy;
        #1;
`ifdef CREDIT_RX_BYPASS_EN
        exp_valid = (q.size() != 0) || iv;
        exp_data  = (q.size() != 0) ? q[0] : id;
        byp       = (q.size() == 0) && iv && rdy;
`else
        exp_valid = (q.size() != 0);
        exp_data  = (q.size() != 0) ? q[0] : '0;
        byp       = 1'b0;
`endif
        chk("o_valid",    64'(bus.o_valid),    64'(exp_valid));
        if (exp_valid) chk("o_data", 64'(bus.o_data), 64'(exp_data));
        chk("o_count",    64'(bus.o_count),    64'(q.size()));
        chk("o_credit",   64'(bus.o_credit),   64'(exp_credit));
        chk("o_overflow", 64'(bus.o_overflow), 64'(exp_ovf));
        if (bus.o_credit === 1'b1) credits_seen++;
        @(posedge clk);
        pop        = exp_valid && rdy;
        exp_credit = pop;
        if (!byp) begin
            if (pop) void'(q.pop_front());
            if (iv) begin
                if (q.size() < DEPTH) q.push_back(id);
                else exp_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"},    64'(bus.o_valid),    64'(0));
        chk({tag, "_count"},    64'(bus.o_count),    64'(0));
        chk({tag, "_credit"},   64'(bus.o_credit),   64'(0));
        chk({tag, "_overflow"}, 64'(bus.o_overflow), 64'(0));
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.o_ready = 1'b0;
        model_reset();
        credits_seen = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single beat 0xA5 with ready held high
        step(1'b1, 32'hA5, 1'b1);
        step(1'b0, 32'h0,  1'b1);
        step(1'b0, 32'h0,  1'b1);
        step(1'b0, 32'h0,  1'b1);

        // Fill to DEPTH without ready, then drain
        credits_seen = 0;
        for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), 1'b0);
        step(1'b0, 32'h0, 1'b0);
        chk("fill_no_credit", 64'(credits_seen), 64'(0));
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);
        chk("drain_credits", 64'(credits_seen), 64'(4));

        // Overflow: full, no ready, extra beat dropped
        for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), 1'b0);
        step(1'b1, 32'h5, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);

        // Full with simultaneous push and pop
        for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), 1'b0);
        step(1'b1, 32'h9, 1'b1);
        chk("full_pushpop_count", 64'(bus.o_count), 64'(4));
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);

        // Continuous streaming with pointer wrap
        credits_seen = 0;
        for (int i = 0; i < 64; i++) begin
            step(1'b1, DW'(32'h100 + i), 1'b1);
            chk("stream_count_le1", 64'(bus.o_count <= 1), 64'(1));
        end
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
        chk("stream_credits", 64'(credits_seen), 64'(64));

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'(($urandom_range(0, 2)) != 0), DW'($urandom), 1'(($urandom_range(0, 3)) != 0));
        end
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);

        // Reset mid-stream with count=3 and a credit pending
        for (int i = 1; i <= 4; i++) step(1'b1, DW'(32'h30 + i), 1'b0);
        step(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.o_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // First beat after release
        step(1'b1, 32'hA5, 1'b1);
        step(1'b0, 32'h0,  1'b1);
        step(1'b0, 32'h0,  1'b1);
        step(1'b0, 32'h0,  1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/credit_rx_buffer.md
# credit_rx_buffer

Receive-side endpoint of the team's credit-flow link. It accepts a valid-only input stream, which has no backpressure, into a DEPTH-entry FIFO and presents it downstream as a valid/ready stream. It returns one credit pulse per entry drained, so the upstream transmitter, whose credit counter resets to DEPTH, can never legally overrun it. It sits at the far end of long or retimed paths where a combinational ready cannot be routed back.

## Interface
- DATA_WIDTH, 32, payload width in bits
- DEPTH, 4, FIFO entries and initial upstream credit count; power of two, ≥ 2
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- i_data  input  DATA_WIDTH  inbound payload
- i_valid  input  1  inbound beat; sampled every cycle, never stalled
- o_credit  output  1  one-cycle pulse; each pulse returns one credit upstream
- o_data  output  DATA_WIDTH  outbound payload
- o_valid  output  1  outbound beat available
- o_ready  input  1  downstream accepts beat when high with o_valid
- o_count  output  $clog2(DEPTH)+1  current FIFO occupancy
- o_overflow  output  1  sticky error: a beat arrived with FIFO full and no pop

## Operation
- Reset is decided: rst_n is asynchronous, active-low; clk is the clock.
- Reset values: o_valid=0, o_credit=0, o_overflow=0, o_count=0; read and write pointers are 0. o_data is don't-care while o_valid=0.
- Storage: circular buffer of DEPTH entries. The write pointer and read pointer each advance modulo DEPTH.
- Full is count==DEPTH. Empty is count==0.
- Push: when i_valid=1, i_data is written at the write pointer, and the write pointer increments.
- Pop: when o_valid && o_ready, the read pointer increments.
- Occupancy update: count += push − pop.
- o_valid = !empty. o_data = mem[read pointer].
- Simultaneous push and pop while full: the push is accepted, count stays DEPTH, and overflow is not flagged.
- Simultaneous push and pop while count==1: the pop drains the old entry, the new entry is stored, and count stays 1.
- Overflow: i_valid=1 while full and no pop in the same cycle.
  - The beat is dropped and memory is unchanged.
  - o_overflow is set next cycle and holds until reset.
  - The pointers and count are not disturbed.
- Credit return: o_credit is registered. It is high in cycle N+1 exactly when a pop occurred in cycle N. A single pulse represents exactly one credit; back-to-back pops give back-to-back pulses.
- No credits are emitted after reset. The transmitter's counter starts at DEPTH.
- Reset mid-stream discards all contents and any pending credit pulse. Both ends must be reset together.

## Timing
- Default latency is 1 cycle: a beat pushed in cycle N is visible on o_valid/o_data in cycle N+1 at the earliest.
- Credit loop: the earliest re-send is pop in N, o_credit in N+1, and the transmitter send in N+2. Full throughput requires DEPTH ≥ round-trip cycles.
- o_count and o_overflow are registered and reflect the state after the previous edge.
- There is no combinational path from o_ready to any output except through registered state. With the bypass macro, o_valid/o_data also depend combinationally on i_valid/i_data.

## Configuration
- CREDIT_RX_BYPASS_EN
  - Defined: when the FIFO is empty and i_valid=1, the block drives o_valid=1 and o_data=i_data combinationally.
    - If o_ready=1 that cycle, the beat is consumed without being written; count is unchanged and o_credit pulses next cycle.
    - If o_ready=0, the beat is written normally.
    - Latency is 0 cycles.
  - Undefined: there is no input-to-output combinational path and latency is always 1 cycle.

## Test plan
- Reset, then a single beat 0xA5 in cycle 0 with o_ready=1 → o_valid=1 with o_data=0xA5 in cycle 1, o_credit=1 in cycle 2, o_count returns to 0.
- DEPTH=4, o_ready=0, push 0x1..0x4 → o_count=4 and no o_credit. Then o_ready=1 → o_data sequence 0x1,0x2,0x3,0x4 on consecutive cycles, and four consecutive o_credit pulses each lagging its pop by 1 cycle.
- Full FIFO, o_ready=0, push 0x5 → o_overflow=1 next cycle and stays set, o_count=4, and drained data is 0x1..0x4 only.
- Full FIFO, o_ready=1 and i_valid=1 with 0x9 in the same cycle → no overflow, o_count stays 4, and 0x9 emerges after 0x2..0x4.
- Continuous i_valid every cycle for 64 beats with o_ready=1 and a pointer wrap → data is in order, o_count ≤ 1, and exactly 64 o_credit pulses.
- Assert rst_n=0 mid-stream with count=3 → o_valid, o_count, o_credit and o_overflow go to 0 immediately (asynchronously), and the first beat after release behaves as in the first scenario.
